sr_latch: RTL and testbench

// - Clocked emulation of a cross-coupled NAND SR latch with active-low S/R inputs.
// - Gives glue logic and control paths a synthesizable, glitch-free set/reset flag.
// - Q/Qbar reproduce NAND-latch truth-table behaviour, including the forbidden state.
// - All state is held in flops on clk; no combinational feedback loops.

---
 rtl/sr_latch.sv | 138 +++++++++++++
 tb/tb_sr_latch.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch.sv
// -----------------------------------------------------------------------------
// sr_latch
//
// Clocked emulation of a cross-coupled NAND SR latch with active-low S/R.
// All state lives in flops on clk; there is no combinational feedback, so the
// outputs are glitch-free and the "forbidden" S=R=0 case is deterministic.
//
// Parameters:
//   SYNC_STAGES  extra input flop stages on S/R before decode (0..3)
//   INIT_Q       Q value on reset (Qbar resets to ~INIT_Q)
//   RACE_Q       Q value when leaving forbidden (00) straight to hold (11)
//
// Ports:
//   Q        out  latch output (registered)
//   Qbar     out  complementary output; equals ~Q except in the forbidden state
//   S        in   set, active-low
//   R        in   reset, active-low
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous reset, active-low
//
// Optional feature (macro SR_LATCH_ERR_EN):
//   err      out  sticky flag, set on any cycle a forbidden sample is decoded
//   err_cnt  out  8-bit saturating count of entries into the forbidden state
// -----------------------------------------------------------------------------
module sr_latch #(
  parameter int SYNC_STAGES = 0,
  parameter bit INIT_Q      = 1'b0,
  parameter bit RACE_Q      = 1'b0
) (
  output logic       Q,
  output logic       Qbar,
  input  logic       S,
  input  logic       R,
  input  logic       clk,
  input  logic       rst_n
`ifdef SR_LATCH_ERR_EN
  ,
  output logic       err,
  output logic [7:0] err_cnt
`endif
);

  // Sampled (optionally synchronized) set/reset, still active-low.
  logic w_s;
  logic w_r;

  generate
    if (SYNC_STAGES == 0) begin : g_no_sync
      assign w_s = S;
      assign w_r = R;
    end else begin : g_sync
      // Pipeline resets to 1 (inactive) so stale inputs are discarded on reset.
      logic [SYNC_STAGES-1:0] r_s_pipe;
      logic [SYNC_STAGES-1:0] r_r_pipe;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_s_pipe <= '1;
          r_r_pipe <= '1;
        end else begin
          r_s_pipe[0] <= S;
          r_r_pipe[0] <= R;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            r_s_pipe[i] <= r_s_pipe[i-1];
            r_r_pipe[i] <= r_r_pipe[i-1];
          end
        end
      end

      assign w_s = r_s_pipe[SYNC_STAGES-1];
      assign w_r = r_r_pipe[SYNC_STAGES-1];
    end
  endgenerate

  logic r_q;
  logic r_qbar;
  logic r_forbidden;  // last decoded sample was S=R=0

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q         <= INIT_Q;
      r_qbar      <= ~INIT_Q;
      r_forbidden <= 1'b0;
    end else begin
      case ({w_s, w_r})
        2'b01: begin
          r_q         <= 1'b1;
          r_qbar      <= 1'b0;
          r_forbidden <= 1'b0;
        end
        2'b10: begin
          r_q         <= 1'b0;
          r_qbar      <= 1'b1;
          r_forbidden <= 1'b0;
        end
        2'b00: begin
          r_q         <= 1'b1;
          r_qbar      <= 1'b1;
          r_forbidden <= 1'b1;
        end
        default: begin
          // Hold. A real NAND latch races when both inputs release together;
          // resolve that race to a fixed, configurable winner.
          if (r_forbidden) begin
            r_q    <= RACE_Q;
            r_qbar <= ~RACE_Q;
          end
          r_forbidden <= 1'b0;
        end
      endcase
    end
  end

  assign Q    = r_q;
  assign Qbar = r_qbar;

`ifdef SR_LATCH_ERR_EN
  logic       r_err;
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err     <= 1'b0;
      r_err_cnt <= 8'h00;
    end else if ({w_s, w_r} == 2'b00) begin
      r_err <= 1'b1;
      // Count only the entry into forbidden, not every cycle spent there.
      if (!r_forbidden && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign err     = r_err;
  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_sr_latch.sv
// -----------------------------------------------------------------------------
// tb_sr_latch
//
// Drives two latch instances from the same S/R stimulus:
//   dut_a: SYNC_STAGES=0, INIT_Q=0, RACE_Q=0
//   dut_b: SYNC_STAGES=2, INIT_Q=1, RACE_Q=1
// A behavioural model (input-history queue + NAND-latch truth table) predicts
// Q/Qbar (and err/err_cnt when SR_LATCH_ERR_EN is defined).
// -----------------------------------------------------------------------------
module tb_sr_latch;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic s     = 1'b1;
  logic r     = 1'b1;

  logic qa, qba, qb, qbb;
`ifdef SR_LATCH_ERR_EN
  logic       erra, errb;
  logic [7:0] cnta, cntb;
`endif

  int total = 0;
  int bad   = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  sr_latch #(.SYNC_STAGES(0), .INIT_Q(1'b0), .RACE_Q(1'b0)) dut_a (
    .Q(qa), .Qbar(qba), .S(s), .R(r), .clk(clk), .rst_n(rst_n)
`ifdef SR_LATCH_ERR_EN
    , .err(erra), .err_cnt(cnta)
`endif
  );

  sr_latch #(.SYNC_STAGES(2), .INIT_Q(1'b1), .RACE_Q(1'b1)) dut_b (
    .Q(qb), .Qbar(qbb), .S(s), .R(r), .clk(clk), .rst_n(rst_n)
`ifdef SR_LATCH_ERR_EN
    , .err(errb), .err_cnt(cntb)
`endif
  );

  // ---------------- reference model ----------------
  // Input history: each entry is the {S,R} seen at a clock edge; the sample
  // decoded at an edge is the one from SYNC_STAGES edges earlier.
  logic [1:0] hist_a[$];
  logic [1:0] hist_b[$];
  logic       ma_q, ma_qb, ma_f, mb_q, mb_qb, mb_f;
  logic       ma_err, mb_err;
  logic [7:0] ma_cnt, mb_cnt;

  // NAND latch truth table, returns {q, qbar, forbidden}.
  function automatic logic [2:0] latch_next(input logic [1:0] smp, input logic q,
                                            input logic qbar, input logic forb,
                                            input logic race);
    logic [2:0] nxt;
    case (smp)
      2'b01:   nxt = 3'b100;
      2'b10:   nxt = 3'b010;
      2'b00:   nxt = 3'b111;
      default: nxt = forb ? {race, ~race, 1'b0} : {q, qbar, 1'b0};
    endcase
    return nxt;
  endfunction

  task automatic model_reset();
    hist_a.delete();
    hist_b.delete();
    for (int i = 0; i < 2; i++) hist_b.push_back(2'b11);
    ma_q = 1'b0; ma_qb = 1'b1; ma_f = 1'b0;
    mb_q = 1'b1; mb_qb = 1'b0; mb_f = 1'b0;
    ma_err = 1'b0; mb_err = 1'b0;
    ma_cnt = 8'h00; mb_cnt = 8'h00;
  endtask

  task automatic model_edge();
    logic [1:0] sa, sb;
    logic [2:0] na, nb;
    hist_a.push_back({s, r});
    hist_b.push_back({s, r});
    sa = hist_a.pop_front();
    sb = hist_b.pop_front();
    if (sa == 2'b00) begin
      ma_err = 1'b1;
      if (!ma_f && ma_cnt != 8'hFF) ma_cnt = ma_cnt + 8'd1;
    end
    if (sb == 2'b00) begin
      mb_err = 1'b1;
      if (!mb_f && mb_cnt != 8'hFF) mb_cnt = mb_cnt + 8'd1;
    end
    na = latch_next(sa, ma_q, ma_qb, ma_f, 1'b0);
    nb = latch_next(sb, mb_q, mb_qb, mb_f, 1'b1);
    {ma_q, ma_qb, ma_f} = na;
    {mb_q, mb_qb, mb_f} = nb;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_qa"},   {7'd0, qa},  {7'd0, ma_q});
    check({tag, "_qbara"}, {7'd0, qba}, {7'd0, ma_qb});
    check({tag, "_qb"},   {7'd0, qb},  {7'd0, mb_q});
    check({tag, "_qbarb"}, {7'd0, qbb}, {7'd0, mb_qb});
`ifdef SR_LATCH_ERR_EN
    check({tag, "_erra"}, {7'd0, erra}, {7'd0, ma_err});
    check({tag, "_cnta"}, cnta, ma_cnt);
    check({tag, "_errb"}, {7'd0, errb}, {7'd0, mb_err});
    check({tag, "_cntb"}, cntb, mb_cnt);
`endif
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge: drive inputs, let the rising edge
  // happen, step the model, then compare at the next falling edge.
  task automatic step(input logic [1:0] sr, input string tag);
    s = sr[1];
    r = sr[0];
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_qa"},   {7'd0, qa},  8'd0);
    check({tag, "_qbara"}, {7'd0, qba}, 8'd1);
    check({tag, "_qb"},   {7'd0, qb},  8'd1);
    check({tag, "_qbarb"}, {7'd0, qbb}, 8'd0);
`ifdef SR_LATCH_ERR_EN
    check({tag, "_erra"}, {7'd0, erra}, 8'd0);
    check({tag, "_cnta"}, cnta, 8'd0);
    check({tag, "_errb"}, {7'd0, errb}, 8'd0);
    check({tag, "_cntb"}, cntb, 8'd0);
`endif
  endtask

  // ---------------- directed + random sequence ----------------
  logic [1:0] seq_sr [6] = '{2'b01, 2'b11, 2'b10, 2'b11, 2'b00, 2'b11};
  logic       seq_q  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic       seq_qb [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    // Asynchronous reset before any clock edge (first rising edge at t=5).
    #1 rst_n = 1'b0;
    #1 check_reset_values("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Set then hold.
    step(2'b01, "set");
    check("set_q_const", {7'd0, qa}, 8'd1);
    step(2'b11, "set_hold");
    check("set_hold_q_const", {7'd0, qa}, 8'd1);

    // Reset then hold for 5 cycles.
    step(2'b10, "reset");
    for (int i = 0; i < 5; i++) step(2'b11, "reset_hold");
    check("reset_hold_qbar_const", {7'd0, qba}, 8'd1);

    // Forbidden then straight to hold: race resolves to RACE_Q.
    step(2'b00, "forbid");
    check("forbid_qbar_const", {7'd0, qba}, 8'd1);
    step(2'b11, "race");
    check("race_q_const", {7'd0, qa}, 8'd0);
    check("race_qbar_const", {7'd0, qba}, 8'd1);
`ifdef SR_LATCH_ERR_EN
    check("race_err_const", {7'd0, erra}, 8'd1);
    check("race_cnt_const", cnta, 8'd1);
`endif

    // Reference sequence with known Q/Qbar trace on the zero-stage latch.
    for (int i = 0; i < 6; i++) begin
      step(seq_sr[i], "seq");
      check("seq_q_const", {7'd0, qa}, {7'd0, seq_q[i]});
      check("seq_qbar_const", {7'd0, qba}, {7'd0, seq_qb[i]});
    end

    // Two-stage latency on dut_b: drive it low first, then set.
    for (int i = 0; i < 3; i++) step(2'b10, "lat_prep");
    for (int i = 0; i < 3; i++) step(2'b11, "lat_prep_hold");
    step(2'b01, "lat_e1");
    check("lat_e1_qb_const", {7'd0, qb}, 8'd0);
    step(2'b11, "lat_e2");
    check("lat_e2_qb_const", {7'd0, qb}, 8'd0);
    step(2'b11, "lat_e3");
    check("lat_e3_qb_const", {7'd0, qb}, 8'd1);

    // Forbidden held for several cycles: no oscillation.
    for (int i = 0; i < 4; i++) step(2'b00, "forbid_hold");
    for (int i = 0; i < 3; i++) step(2'b11, "forbid_exit");

    // Randomized stimulus, biased toward hold so states persist.
    for (int i = 0; i < 120; i++) begin
      logic [1:0] sr;
      sr = ($urandom_range(0, 2) == 0) ? 2'b11 : 2'($urandom_range(0, 3));
      step(sr, "rand");
    end

    // Reset mid-operation while sitting in forbidden.
    step(2'b00, "pre_rst");
    step(2'b00, "pre_rst");
    #2 rst_n = 1'b0;
    #1 check_reset_values("mid_rst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_reset_values("mid_rst_held");
    rst_n = 1'b1;
    // Inputs released to hold: nothing from before reset may leak through.
    for (int i = 0; i < 4; i++) step(2'b11, "post_rst");
    for (int i = 0; i < 20; i++) step(2'($urandom_range(0, 3)), "post_rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
